ym6045c_sr_n: RTL

Parametrised shift-register cell for the arbiter netlist. It is the generalised successor to the fixed 8-bit shift-register cell and the fixed short/med/long delay cells.
- Adds hold / shift-left / shift-right / parallel-load modes.
- Adds a selectable delay tap.
- Adds a counted burst-shift engine with busy/done handshake.
- Used wherever the arbiter needs programmable delays or serial strobe sequences.

---
 rtl/ym6045c_sr_n.sv | 86 ++++++++
 1 files changed

// File: rtl/ym6045c_sr_n.sv
// ym6045c_sr_n: shift register with hold/shift/load modes, selectable tap and a counted burst-shift engine
module ym6045c_sr_n #(
    parameter int WIDTH = 8,
    parameter int TAPW  = 3,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin,
    input  logic [WIDTH-1:0] pin,
    input  logic [TAPW-1:0]  tap_sel,
    input  logic [CNT_W-1:0] burst_len,
    input  logic             burst_go,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             tap_out,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] q_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             dir, dir_n, done_n;
    logic             shift_dir;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            q     <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_n;
            q     <= q_n;
            cnt   <= cnt_n;
            dir   <= dir_n;
            done  <= done_n;
        end
    end

    // dir: 0 = left, 1 = right; a burst start shifts nothing on its own edge
    always_comb begin
        state_n   = state;
        q_n       = q;
        cnt_n     = cnt;
        dir_n     = dir;
        done_n    = 1'b0;
        shift_dir = mode[1];
        if (state == RUN) begin
            shift_dir = dir;
            if (en) begin
                q_n   = shift_dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
                cnt_n = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end
            end
        end else if (burst_go && (mode[0] ^ mode[1])) begin
            dir_n = en ? mode[1] : dir;
            if (burst_len != '0) begin
                state_n = RUN;
                cnt_n   = burst_len;
                dir_n   = mode[1];
            end else begin
                done_n = 1'b1;
            end
        end else if (en) begin
            if (mode == 2'b11)
                q_n = pin;
            else if (mode != 2'b00) begin
                q_n   = shift_dir ? {sin, q[WIDTH-1:1]} : {q[WIDTH-2:0], sin};
                dir_n = shift_dir;
            end
        end
    end

    assign busy    = (state == RUN);
    assign sout    = dir ? q[0] : q[WIDTH-1];
    assign tap_out = (32'(tap_sel) < WIDTH) ? q[tap_sel] : 1'b0;
endmodule
